// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t              r_state;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_m;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg;
  logic                r_early;
  logic [4:0]          r_rd_l;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd;
  logic                w_accept, w_sa, w_sb, w_div0, w_ovf, w_early, w_ge;
  logic [XLEN-1:0]     w_ma, w_mb, w_spec, w_init, w_q, w_r, w_res;
  logic [XLEN:0]       w_add, w_rsh, w_diff;
  logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_nxt, w_prod;
  assign busy_o   = (r_state == CALC);
  assign done_o   = (r_state == DONE);
  assign result_o = r_result;
  assign rd_o     = r_rd;
  assign w_accept = start_i & ~flush_i & (r_state != CALC);
  // a is signed for MULH/MULHSU/DIV/REM, b only for MULH/DIV/REM
  assign w_sa = ((op_i == 3'b001) | (op_i == 3'b010) | (op_i == 3'b100) | (op_i == 3'b110)) & a_i[XLEN-1];
  assign w_sb = ((op_i == 3'b001) | (op_i == 3'b100) | (op_i == 3'b110)) & b_i[XLEN-1];
  assign w_ma = w_sa ? -a_i : a_i;
  assign w_mb = w_sb ? -b_i : b_i;
  assign w_div0 = op_i[2] & (b_i == '0);
  assign w_ovf  = op_i[2] & ~op_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);
  assign w_spec = w_div0 ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_ax, w_bx, w_fp;
  assign w_ax    = {{XLEN{w_sa}}, a_i};
  assign w_bx    = {{XLEN{w_sb}}, b_i};
  assign w_fp    = w_ax * w_bx;
  assign w_early = w_div0 | w_ovf | ~op_i[2];
  assign w_init  = ~op_i[2] ? ((op_i[1:0] == 2'b00) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN]) :
                   (w_div0 | w_ovf) ? w_spec : w_ma;
`else
  assign w_early = w_div0 | w_ovf;
  assign w_init  = w_early ? w_spec : (op_i[2] ? w_ma : w_mb);
`endif
  // multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}
  assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nxt = {w_add, r_acc[XLEN-1:1]};
  assign w_rsh     = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rsh - {1'b0, r_m};
  assign w_ge      = ~w_diff[XLEN];
  assign w_div_nxt = {w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
  assign w_nxt     = r_op[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod    = r_neg ? -w_nxt : w_nxt;
  assign w_q       = w_nxt[XLEN-1:0];
  assign w_r       = w_nxt[2*XLEN-1:XLEN];
  assign w_res     = r_op[2] ? (r_op[1] ? (r_neg ? -w_r : w_r) : (r_neg ? -w_q : w_q)) :
                     (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_early  <= 1'b0;
      r_rd_l   <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (r_state == CALC) begin
      if (flush_i) begin
        r_state <= IDLE;
      end else if (r_early || r_cnt == CNT_W'(XLEN - 1)) begin
        r_state  <= DONE;
        r_result <= r_early ? r_acc[XLEN-1:0] : w_res;
        r_rd     <= r_rd_l;
      end else begin
        r_acc <= w_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (w_accept) begin
      r_state <= CALC;
      r_op    <= op_i;
      r_m     <= op_i[2] ? w_mb : w_ma;
      r_acc   <= {{XLEN{1'b0}}, w_init};
      r_cnt   <= '0;
      r_neg   <= (op_i[2] & op_i[1]) ? w_sa : (w_sa ^ w_sb);
      r_early <= w_early;
      r_rd_l  <= rd_i;
    end else begin
      r_state <= IDLE;
    end
  end
endmodule
